// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps {A,B,C,D} 0..15, samples f_in after each hold, checks against EXPECTED
// Ports: clk/rst (sync active-high), start (pulse or level), f_in (DUT response),
//        abcd (vector to DUT), busy, done, pass (valid with done), table_out (captured f),
//        mismatch_cnt (0..16), first_fail (lowest failing index, 0 when none).
// Optional: define TTC_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module truth_table_capture #(
   parameter int          HOLD_CYCLES = 20,
   parameter logic [15:0] EXPECTED    = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        f_in,
   output logic [3:0]  abcd,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] table_out,
   output logic [4:0]  mismatch_cnt,
   output logic [3:0]  first_fail
);
   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
   localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);
   state_t      state_q, state_d;
   logic [3:0]  abcd_q, abcd_d, ff_q, ff_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] tbl_q, tbl_d;
   logic [4:0]  mm_q, mm_d, mm_inc;
   logic        seen_q, seen_d, pass_q, pass_d;
   logic        miss, stop;
   assign miss   = f_in != EXPECTED[abcd_q];
   assign mm_inc = mm_q + {4'd0, miss};
`ifdef TTC_STOP_ON_FAIL_EN
   assign stop = miss;
`else
   assign stop = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      abcd_d  = abcd_q;
      cnt_d   = cnt_q;
      tbl_d   = tbl_q;
      mm_d    = mm_q;
      ff_d    = ff_q;
      seen_d  = seen_q;
      pass_d  = pass_q;
      if (state_q != DRIVE && start) begin
         state_d = DRIVE;
         abcd_d  = '0;
         cnt_d   = '0;
         tbl_d   = '0;
         mm_d    = '0;
         ff_d    = '0;
         seen_d  = 1'b0;
         pass_d  = 1'b0;
      end else if (state_q == DRIVE) begin
         if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 8'd1;
         end else begin
            cnt_d         = '0;
            tbl_d[abcd_q] = f_in;
            mm_d          = mm_inc;
            if (miss && !seen_q) begin
               ff_d   = abcd_q;
               seen_d = 1'b1;
            end
            // pass uses the count including this final compare
            if (abcd_q == 4'hF || stop) begin
               state_d = DONE;
               pass_d  = mm_inc == 5'd0;
            end else begin
               abcd_d = abcd_q + 4'd1;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         abcd_q  <= '0;
         cnt_q   <= '0;
         tbl_q   <= '0;
         mm_q    <= '0;
         ff_q    <= '0;
         seen_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         abcd_q  <= abcd_d;
         cnt_q   <= cnt_d;
         tbl_q   <= tbl_d;
         mm_q    <= mm_d;
         ff_q    <= ff_d;
         seen_q  <= seen_d;
         pass_q  <= pass_d;
      end
   end
   assign abcd         = abcd_q;
   assign busy         = state_q == DRIVE;
   assign done         = state_q == DONE;
   assign pass         = pass_q;
   assign table_out    = tbl_q;
   assign mismatch_cnt = mm_q;
   assign first_fail   = ff_q;
endmodule
